// File: rtl/core_pc_pred.sv
// Fetch-address stage: PC register plus BTB / gshare PHT / global-history next-PC prediction.
// Prediction is combinational off the PC register; training is written at the clock edge from the resolving stage.
module core_pc_pred #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BTB_IDX  = 4,
  parameter int          PHT_IDX  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        update_v,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic [1:0]  update_type,
  input  logic [1:0]  update_PHT,
  input  logic [2:0]  update_BHR,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] pred_target,
  output logic [1:0]  delayed_PHT,
  output logic [2:0]  delayed_BHR,
  output logic [1:0]  btb_type,
  output logic        btb_v
);

  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = 30 - BTB_IDX;
  localparam int PHT_N = 1 << PHT_IDX;

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [2:0]       bhr_reg;

  logic             btb_valid_reg  [BTB_N];
  logic [TAG_W-1:0] btb_tag_reg    [BTB_N];
  logic [31:0]      btb_target_reg [BTB_N];
  logic [1:0]       btb_type_reg   [BTB_N];
  logic [1:0]       pht_reg        [PHT_N];

  // Fetch-side lookup
  logic [BTB_IDX-1:0] fetch_bidx;
  logic [TAG_W-1:0]   fetch_tag;
  logic [PHT_IDX-1:0] fetch_pidx;
  logic               btb_hit;
  logic [1:0]         pht_rd;
  logic               pred_taken;

  assign fetch_bidx = pc_reg[BTB_IDX+1:2];
  assign fetch_tag  = pc_reg[31:BTB_IDX+2];
  assign fetch_pidx = pc_reg[PHT_IDX+1:2] ^ PHT_IDX'(bhr_reg);

  assign btb_hit    = btb_valid_reg[fetch_bidx] && (btb_tag_reg[fetch_bidx] == fetch_tag);
  assign pht_rd     = pht_reg[fetch_pidx];
  // Unconditional kinds (jump/indirect) are always taken on a hit; conditionals follow the counter MSB.
  assign pred_taken = btb_hit && ((btb_type_reg[fetch_bidx] != 2'b00) || pht_rd[1]);

  assign pc          = pc_reg;
  assign pc_plus_4   = pc_reg + 32'd4;
  assign pred_target = pred_taken ? btb_target_reg[fetch_bidx] : pc_plus_4;
  assign btb_v       = btb_hit;
  assign btb_type    = btb_hit ? btb_type_reg[fetch_bidx] : 2'b00;
  assign delayed_PHT = pht_rd;
  assign delayed_BHR = bhr_reg;

  // Training side
  logic [BTB_IDX-1:0] upd_bidx;
  logic [TAG_W-1:0]   upd_tag;
  logic [PHT_IDX-1:0] upd_pidx;
  logic               pht_train;
  logic               btb_train;
  logic [1:0]         pht_wr;

  assign upd_bidx  = update_pc[BTB_IDX+1:2];
  assign upd_tag   = update_pc[31:BTB_IDX+2];
  assign upd_pidx  = update_pc[PHT_IDX+1:2] ^ PHT_IDX'(update_BHR);
  assign pht_train = update_v && (update_type == 2'b00);
  assign btb_train = update_v && update_taken;

  // New counter is derived from the value seen at prediction time, not the current table entry.
  always_comb begin
    pht_wr = update_PHT;
    if (update_taken) begin
      if (update_PHT != 2'b11) pht_wr = update_PHT + 2'b01;
    end else begin
      if (update_PHT != 2'b00) pht_wr = update_PHT - 2'b01;
    end
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect)   pc_next = redirect_pc;
    else if (pc_we) pc_next = pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= RESET_PC;
      bhr_reg <= 3'b000;
    end else begin
      pc_reg <= pc_next;
      if (pht_train) bhr_reg <= {bhr_reg[1:0], update_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) btb_valid_reg[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht_reg[i] <= 2'b01;
    end else begin
      if (btb_train) btb_valid_reg[upd_bidx] <= 1'b1;
      if (pht_train) pht_reg[upd_pidx] <= pht_wr;
    end
  end

  // Payload fields need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && btb_train) begin
      btb_tag_reg[upd_bidx]    <= upd_tag;
      btb_target_reg[upd_bidx] <= update_target;
      btb_type_reg[upd_bidx]   <= update_type;
    end
  end

endmodule

// File: tb/tb_core_pc_pred.sv
// Scoreboard bench for core_pc_pred: expected fetch outputs are queued per transaction and
// compared after the edge that produces them.
module tb_core_pc_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_we;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        update_v;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [1:0]  update_type;
  logic [1:0]  update_PHT;
  logic [2:0]  update_BHR;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] pred_target;
  logic [1:0]  delayed_PHT;
  logic [2:0]  delayed_BHR;
  logic [1:0]  btb_type;
  logic        btb_v;

  always #5 clk = ~clk;

  core_pc_pred dut (
    .clk          (clk),
    .rst          (rst),
    .pc_we        (pc_we),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .update_v     (update_v),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_target(update_target),
    .update_type  (update_type),
    .update_PHT   (update_PHT),
    .update_BHR   (update_BHR),
    .pc           (pc),
    .pc_plus_4    (pc_plus_4),
    .pred_target  (pred_target),
    .delayed_PHT  (delayed_PHT),
    .delayed_BHR  (delayed_BHR),
    .btb_type     (btb_type),
    .btb_v        (btb_v)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic        v;
    logic [1:0]  typ;
    logic [1:0]  pht;
    logic [2:0]  bhr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%08h want=%08h", tag, got, want);
    else n_pass++;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] epc, input logic [31:0] epred,
                            input logic ev, input logic [1:0] etyp, input logic [1:0] epht,
                            input logic [2:0] ebhr);
    exp_t e;
    e.pc = epc; e.pred = epred; e.v = ev; e.typ = etyp; e.pht = epht; e.bhr = ebhr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    $display("txn %-12s pc=%08h pc4=%08h pred=%08h v=%0b type=%0d pht=%0d bhr=%0d",
             t, pc, pc_plus_4, pred_target, btb_v, btb_type, delayed_PHT, delayed_BHR);
    check_val({t, ".pc"},   pc,                  e.pc);
    check_val({t, ".pc4"},  pc_plus_4,           e.pc + 32'd4);
    check_val({t, ".pred"}, pred_target,         e.pred);
    check_val({t, ".v"},    {31'd0, btb_v},      {31'd0, e.v});
    check_val({t, ".type"}, {30'd0, btb_type},   {30'd0, e.typ});
    check_val({t, ".pht"},  {30'd0, delayed_PHT}, {30'd0, e.pht});
    check_val({t, ".bhr"},  {29'd0, delayed_BHR}, {29'd0, e.bhr});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic clear_in();
    rst = 1'b0; pc_we = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    update_v = 1'b0; update_pc = 32'd0; update_taken = 1'b0; update_target = 32'd0;
    update_type = 2'b00; update_PHT = 2'b00; update_BHR = 3'b000;
  endtask

  task automatic set_upd(input logic [31:0] upc, input logic tkn, input logic [31:0] tgt,
                         input logic [1:0] typ, input logic [1:0] pht, input logic [2:0] bhr);
    update_v = 1'b1; update_pc = upc; update_taken = tkn; update_target = tgt;
    update_type = typ; update_PHT = pht; update_BHR = bhr;
  endtask

  task automatic set_redir(input logic [31:0] rpc);
    redirect = 1'b1; redirect_pc = rpc;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    expect_out("reset", 32'h0, 32'h4, 1'b0, 2'd0, 2'd1, 3'd0); tick();

    clear_in(); pc_we = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      expect_out("seq", 32'(4 * i), 32'(4 * i + 4), 1'b0, 2'd0, 2'd1, 3'd0); tick();
    end
    pc_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_out("hold", 32'hC, 32'h10, 1'b0, 2'd0, 2'd1, 3'd0); tick();
    end

    // Jump at 0x10 -> 0x40, then fetch it
    set_upd(32'h10, 1'b1, 32'h40, 2'b01, 2'b00, 3'b000);
    expect_out("btb_upd", 32'hC, 32'h10, 1'b0, 2'd0, 2'd1, 3'd0); tick();
    clear_in(); set_redir(32'h10); pc_we = 1'b1;
    expect_out("redir_hit", 32'h10, 32'h40, 1'b1, 2'd1, 2'd1, 3'd0); tick();
    clear_in(); pc_we = 1'b1;
    expect_out("jump", 32'h40, 32'h44, 1'b0, 2'd0, 2'd1, 3'd0); tick();

    // Conditional at 0x20: PHT[8] 01->10, BHR 000->001
    clear_in(); set_upd(32'h20, 1'b1, 32'h80, 2'b00, 2'b01, 3'b000);
    expect_out("cond_upd", 32'h40, 32'h44, 1'b0, 2'd0, 2'd1, 3'd1); tick();
    clear_in(); set_redir(32'h20);
    expect_out("cond_fetch", 32'h20, 32'h24, 1'b1, 2'd0, 2'd1, 3'd1); tick();
    clear_in(); set_redir(32'h24);
    expect_out("pht8", 32'h24, 32'h28, 1'b0, 2'd0, 2'd2, 3'd1); tick();

    // Saturate high at PHT[9], concurrent with redirect and pc_we
    clear_in(); set_upd(32'h20, 1'b1, 32'h80, 2'b00, 2'b11, 3'b001);
    set_redir(32'h28); pc_we = 1'b1;
    expect_out("sat_hi", 32'h28, 32'h2C, 1'b0, 2'd0, 2'd3, 3'd3); tick();

    // Saturate low at PHT[11]; BTB entry for 0x20 must survive a not-taken update
    clear_in(); set_upd(32'h20, 1'b0, 32'h0, 2'b00, 2'b00, 3'b011); set_redir(32'h20);
    expect_out("sat_lo_btb", 32'h20, 32'h24, 1'b1, 2'd0, 2'd1, 3'd6); tick();
    clear_in(); set_redir(32'h34);
    expect_out("sat_lo", 32'h34, 32'h38, 1'b0, 2'd0, 2'd0, 3'd6); tick();

    // Train PHT[13] to 10 so the next fetch of 0x20 (BHR=101) predicts taken
    clear_in(); set_upd(32'h20, 1'b1, 32'h80, 2'b00, 2'b01, 3'b101); set_redir(32'h20);
    expect_out("cond_taken", 32'h20, 32'h80, 1'b1, 2'd0, 2'd2, 3'd5); tick();

    // Same-cycle fetch of the updated pc sees old contents
    clear_in(); set_upd(32'h20, 1'b1, 32'h200, 2'b01, 2'b00, 3'b000);
    expect_out("no_bypass", 32'h20, 32'h80, 1'b1, 2'd0, 2'd2, 3'd5);
    #1; compare_out();
    expect_out("after_upd", 32'h20, 32'h200, 1'b1, 2'd1, 2'd2, 3'd5); tick();

    // Wrap-around and redirect priority over pc_we
    clear_in(); set_redir(32'hFFFF_FFFC); pc_we = 1'b1;
    expect_out("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 2'd0, 2'd1, 3'd5); tick();
    clear_in(); pc_we = 1'b1;
    expect_out("wrap_next", 32'h0, 32'h4, 1'b0, 2'd0, 2'd1, 3'd5); tick();
    clear_in(); set_redir(32'h100); pc_we = 1'b1;
    expect_out("redir_pri", 32'h100, 32'h104, 1'b0, 2'd0, 2'd1, 3'd5); tick();

    // Reset mid-operation discards same-cycle training and redirect
    clear_in(); rst = 1'b1; set_upd(32'h10, 1'b1, 32'h300, 2'b00, 2'b01, 3'b000);
    set_redir(32'h500); pc_we = 1'b1;
    expect_out("mid_rst", 32'h0, 32'h4, 1'b0, 2'd0, 2'd1, 3'd0); tick();
    clear_in(); set_redir(32'h10);
    expect_out("rst_btb10", 32'h10, 32'h14, 1'b0, 2'd0, 2'd1, 3'd0); tick();
    clear_in(); set_redir(32'h20);
    expect_out("rst_btb20", 32'h20, 32'h24, 1'b0, 2'd0, 2'd1, 3'd0); tick();

    if (exp_q.size() != 0) check_val("scoreboard_left", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_pc_pred.md
Name: core_pc_pred

Overview:
- Fetch-address stage with branch prediction; sits directly upstream of the IF/ID pipeline register and feeds it.
- Holds the PC and predicts the next PC using three structures: a direct-mapped BTB, a gshare-style PHT of 2-bit counters, and a 3-bit global history register (BHR).
- Exports the prediction metadata the IF/ID register carries down the pipe.
- Accepts redirects and predictor-training updates from the resolving stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_IDX, 4, log2 of BTB entries (16); BTB index = pc[BTB_IDX+1:2], tag = pc[31:BTB_IDX+2].
- PHT_IDX, 6, log2 of PHT entries (64); PHT index = pc[PHT_IDX+1:2] XOR zero-extended BHR.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_we  in  1  advance PC to the predicted target (deasserted = stall).
- redirect  in  1  mispredict/exception redirect request.
- redirect_pc  in  32  redirect target.
- update_v  in  1  training update valid.
- update_pc  in  32  PC of the resolved control instruction.
- update_taken  in  1  resolved direction.
- update_target  in  32  resolved target.
- update_type  in  2  00 cond, 01 jump, 10 indirect, 11 treated as jump.
- update_PHT  in  2  counter value sampled at prediction (delayed_PHT carried down).
- update_BHR  in  3  BHR sampled at prediction (delayed_BHR carried down).
- pc  out  32  current fetch PC.
- pc_plus_4  out  32  pc + 4, modulo 2^32.
- pred_target  out  32  predicted next PC.
- delayed_PHT  out  2  PHT counter read for the current pc.
- delayed_BHR  out  3  BHR value used for indexing.
- btb_type  out  2  type field of the hit entry; 00 on miss.
- btb_v  out  1  BTB hit.

Behaviour:
- pc register next-state priority:
  - rst → RESET_PC.
  - else redirect → redirect_pc (wins over pc_we).
  - else pc_we → pred_target.
  - else hold.
- Prediction outputs are combinational from the pc register and current table contents, so they are valid in the same cycle IF/ID samples the instruction.
- Hit: btb_v = valid[idx] && tag[idx] == pc tag.
- Taken decision:
  - hit && type==00 → taken = PHT[pidx][1].
  - hit && type!=00 → taken = 1.
  - miss → not taken.
- pred_target = taken ? btb_target[idx] : pc_plus_4.
- Outputs from a miss: btb_type = 00, delayed_PHT still reports PHT[pidx], delayed_BHR = BHR.
- Training applies only when update_v = 1, written at the clock edge. Reads in the same cycle see pre-update contents; there is no bypass.
- PHT training (update_type==00 only):
  - Entry index is update_pc[PHT_IDX+1:2] XOR update_BHR.
  - The written value is update_PHT incremented (if taken) or decremented (if not taken), saturating at 11 and 00.
  - The current table content is not used.
- BHR training (update_type==00 only): BHR <= {BHR[1:0], update_taken}. BHR is non-speculative and never altered by fetch.
- BTB training:
  - update_taken = 1 → write valid = 1, tag, target = update_target, type = update_type at update_pc's index, overwriting any alias.
  - Not-taken → BTB unchanged.
- Simultaneous events: redirect, pc_we and update_v are independent. Redirect and training in the same cycle both take effect.
- Reset:
  - Clears all BTB valid bits, sets every PHT entry to 01 (weakly not-taken), sets BHR to 000 and pc to RESET_PC.
  - Reset mid-operation discards any same-cycle update or redirect.
- Output values after reset (RESET_PC = 0): pc = 0, pc_plus_4 = 4, pred_target = 4, btb_v = 0, btb_type = 00, delayed_PHT = 01, delayed_BHR = 000.
- Wrap-around: pc = 32'hFFFF_FFFC gives pc_plus_4 = 0 on a miss.

Test Plan:
- Reset then pc_we = 1 for 3 cycles → pc = 4, 8, 12, each with btb_v = 0. pc_we = 0 for 2 cycles → pc holds at 12.
- update_v with pc = 0x10, taken = 1, target = 0x40, type = 01, then redirect to 0x10 → btb_v = 1, btb_type = 01, pred_target = 0x40. Next pc_we → pc = 0x40.
- Conditional update with pc = 0x20, taken = 1, target = 0x80, PHT = 01, BHR = 000 → PHT[8] = 10, BHR = 001. Fetching 0x20 then indexes PHT[9] = 01 → btb_v = 1, btb_type = 00, delayed_BHR = 001, delayed_PHT = 01, pred_target = 0x24.
- Saturation:
  - update_PHT = 11, taken → entry stays 11.
  - update_PHT = 00, not taken → entry stays 00; a not-taken update to a BTB-resident pc leaves its BTB entry valid.
- Priority and concurrency:
  - redirect = 1, redirect_pc = 0x100 with pc_we = 1 → pc = 0x100.
  - Concurrent update_v in the same cycle is applied (verified on a later fetch).
  - A same-cycle fetch of update_pc still sees old table contents.
- Reset mid-operation after training, with update_v asserted in the reset cycle → pc = 0, BTB misses on 0x10/0x20, PHT reads 01, BHR = 000.
